// File: rtl/hs_fifo_sender.sv
// hs_fifo_sender: small FIFO feeding a request/acknowledge handshake sender.
// Words written on din are queued, then presented one at a time on bus_data
// with rqst signalled in four-phase (PHASE=4) or two-phase (PHASE=2) style.
// ack is asynchronous and enters through a SYNC-stage flop chain.
module hs_fifo_sender #(
  parameter int B     = 16,
  parameter int D     = 4,
  parameter int PHASE = 4,
  parameter int SYNC  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [B-1:0]           din,
  output logic                   full,
  output logic [$clog2(D+1)-1:0] count,
  input  logic                   ack,
  output logic                   rqst,
  output logic [B-1:0]           bus_data
);

  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D+1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SETUP    = 2'd1;
  localparam logic [1:0] WAIT_ACK = 2'd2;
  localparam logic [1:0] WAIT_REL = 2'd3;

  logic [1:0]    state;
  logic [B-1:0]  mem [D];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [SYNC-1:0] ack_sync;
  logic          ack_s;
  logic          wr;
  logic          pop;

  assign ack_s = ack_sync[SYNC-1];
  assign full  = (count == CW'(D));
  assign wr    = en & ~full;
  // In four-phase mode the previous handshake must be fully released first.
  assign pop   = (state == IDLE) && (count != '0) && ((PHASE == 2) || !ack_s);

  // Synchronise the asynchronous acknowledge into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC-2:0], ack};
    end
  end

  // FIFO storage; no reset needed since pointers define validity.
  always_ff @(posedge clk) begin
    if (wr && !rst) begin
      mem[wptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally because D is a power of 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Handshake sequencer: load head word, raise/toggle rqst, wait for ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rqst     <= 1'b0;
      bus_data <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            bus_data <= mem[rptr];
            state    <= SETUP;
          end
        end
        SETUP: begin
          if (PHASE == 2) begin
            rqst <= ~rqst;
          end else begin
            rqst <= 1'b1;
          end
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (PHASE == 2) begin
            if (ack_s == rqst) begin
              state <= IDLE;
            end
          end else if (ack_s) begin
            rqst  <= 1'b0;
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!ack_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hs_fifo_sender.sv
// Testbench for hs_fifo_sender: one four-phase and one two-phase instance,
// scoreboard queues hold the expected bus_data order.
module tb_hs_fifo_sender;

  logic        clk;
  logic        rst;
  logic        en4, ack4, full4, rqst4;
  logic [15:0] din4, bus4;
  logic [2:0]  count4;
  logic        en2, ack2, full2, rqst2;
  logic [15:0] din2, bus2;
  logic [2:0]  count2;

  int checks = 0;
  int errors = 0;
  logic [15:0] q4[$];
  logic [15:0] q2[$];

  hs_fifo_sender #(.B(16), .D(4), .PHASE(4), .SYNC(2)) u_dut4 (
    .clk(clk), .rst(rst), .en(en4), .din(din4), .full(full4), .count(count4),
    .ack(ack4), .rqst(rqst4), .bus_data(bus4)
  );

  hs_fifo_sender #(.B(16), .D(4), .PHASE(2), .SYNC(2)) u_dut2 (
    .clk(clk), .rst(rst), .en(en2), .din(din2), .full(full2), .count(count2),
    .ack(ack2), .rqst(rqst2), .bus_data(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Four-phase receiver for one word: ack dly cycles after rqst rise,
  // release dly cycles after rqst fall; checks data against the scoreboard.
  task automatic recv4(input int dly);
    int n;
    logic [15:0] want;
    n = 0;
    while (rqst4 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (rqst4 !== 1'b1) begin
      errors++;
      $display("FAIL recv4_rqst_rise: rqst=%b required 1 within 100 cycles", rqst4);
      return;
    end
    checks++;
    if (q4.size() == 0) begin
      errors++;
      $display("FAIL recv4_scoreboard: bus=%h but no word expected", bus4);
      want = bus4;
    end else begin
      want = q4.pop_front();
      if (bus4 !== want) begin
        errors++;
        $display("FAIL recv4_data: bus=%h required %h", bus4, want);
      end
    end
    repeat (dly) @(negedge clk);
    ack4 = 1'b1;
    n = 0;
    while (rqst4 !== 1'b0 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (rqst4 !== 1'b0) begin
      errors++;
      $display("FAIL recv4_rqst_fall: rqst=%b required 0", rqst4);
    end
    checks++;
    if (bus4 !== want) begin
      errors++;
      $display("FAIL recv4_bus_stable: bus=%h required %h", bus4, want);
    end
    repeat (dly) @(negedge clk);
    ack4 = 1'b0;
  endtask

  // One word into an empty, idle four-phase sender with latency checks.
  task automatic do_single(input logic [15:0] w);
    int n;
    en4 = 1'b1; din4 = w; q4.push_back(w);
    @(negedge clk);
    en4 = 1'b0;
    checks++;
    if (count4 !== 3'd1 || rqst4 !== 1'b0) begin
      errors++;
      $display("FAIL single_after_t: count=%0d rqst=%b required 1,0", count4, rqst4);
    end
    @(negedge clk);
    checks++;
    if (bus4 !== q4[0] || rqst4 !== 1'b0 || count4 !== 3'd0) begin
      errors++;
      $display("FAIL single_t1: bus=%h rqst=%b count=%0d required %h,0,0", bus4, rqst4, count4, q4[0]);
    end
    void'(q4.pop_front());
    @(negedge clk);
    checks++;
    if (rqst4 !== 1'b1) begin
      errors++;
      $display("FAIL single_t2_rqst: rqst=%b required 1", rqst4);
    end
    repeat (3) @(negedge clk);
    ack4 = 1'b1;
    n = 0;
    while (rqst4 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rqst4 !== 1'b0 || n < 2 || n > 3) begin
      errors++;
      $display("FAIL single_ack_latency: rqst=%b edges=%0d required 0 within 2..3", rqst4, n);
    end
    repeat (3) @(negedge clk);
    ack4 = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (rqst4 !== 1'b0 || count4 !== 3'd0 || bus4 !== w) begin
      errors++;
      $display("FAIL single_idle: rqst=%b count=%0d bus=%h required 0,0,%h", rqst4, count4, bus4, w);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en4 = 1'b1; din4 = 16'hFFFF; ack4 = 1'b0;
    en2 = 1'b1; din2 = 16'hFFFF; ack2 = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rqst4 !== 1'b0 || bus4 !== 16'h0 || count4 !== 3'd0 || full4 !== 1'b0) begin
      errors++;
      $display("FAIL reset4: rqst=%b bus=%h count=%0d full=%b required 0,0000,0,0", rqst4, bus4, count4, full4);
    end
    checks++;
    if (rqst2 !== 1'b0 || bus2 !== 16'h0 || count2 !== 3'd0 || full2 !== 1'b0) begin
      errors++;
      $display("FAIL reset2: rqst=%b bus=%h count=%0d full=%b required 0,0000,0,0", rqst2, bus2, count2, full2);
    end
    en4 = 1'b0; en2 = 1'b0; rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (count4 !== 3'd0 || rqst4 !== 1'b0 || count2 !== 3'd0 || rqst2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_writes_dropped: count4=%0d rqst4=%b count2=%0d rqst2=%b required 0", count4, rqst4, count2, rqst2);
    end
  endtask

  task automatic test_single();
    do_single(16'h0001);
  endtask

  task automatic test_full();
    ack4 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      en4 = 1'b1; din4 = 16'(i);
      if (i <= 5) q4.push_back(16'(i));
      @(negedge clk);
    end
    en4 = 1'b0;
    checks++;
    if (count4 !== 3'd4 || full4 !== 1'b1) begin
      errors++;
      $display("FAIL full_fill: count=%0d full=%b required 4,1", count4, full4);
    end
    checks++;
    if (bus4 !== 16'h0001) begin
      errors++;
      $display("FAIL full_head_on_bus: bus=%h required 0001", bus4);
    end
    for (int k = 0; k < 5; k++) recv4(1);
    repeat (6) @(negedge clk);
    checks++;
    if (count4 !== 3'd0 || full4 !== 1'b0 || q4.size() != 0) begin
      errors++;
      $display("FAIL full_drain: count=%0d full=%b pending=%0d required 0,0,0", count4, full4, q4.size());
    end
  endtask

  task automatic test_simul_wrap();
    int n;
    int wi;
    ack4 = 1'b0;
    en4 = 1'b1; din4 = 16'h0021; q4.push_back(16'h0021); @(negedge clk);
    din4 = 16'h0022; q4.push_back(16'h0022); @(negedge clk);
    din4 = 16'h0023; q4.push_back(16'h0023); @(negedge clk);
    en4 = 1'b0;
    n = 0;
    while (rqst4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rqst4 !== 1'b1 || bus4 !== q4[0] || count4 !== 3'd2) begin
      errors++;
      $display("FAIL simul_pre: rqst=%b bus=%h count=%0d required 1,%h,2", rqst4, bus4, count4, q4[0]);
    end
    void'(q4.pop_front());
    ack4 = 1'b1;
    n = 0;
    while (rqst4 !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    ack4 = 1'b0;
    // ack_s low after 2 edges, WAIT_REL->IDLE on the 3rd, pop on the 4th.
    repeat (3) @(negedge clk);
    en4 = 1'b1; din4 = 16'h0024; q4.push_back(16'h0024);
    @(negedge clk);
    en4 = 1'b0;
    checks++;
    if (count4 !== 3'd2 || bus4 !== q4[0]) begin
      errors++;
      $display("FAIL simul_write_pop: count=%0d bus=%h required 2,%h", count4, bus4, q4[0]);
    end
    for (int k = 0; k < 3; k++) recv4(1);
    wi = 0;
    fork
      begin
        for (int c = 0; c < 400 && wi < 10; c++) begin
          if (full4 === 1'b0) begin
            en4 = 1'b1; din4 = 16'h0100 + 16'(wi); q4.push_back(16'h0100 + 16'(wi)); wi++;
          end else begin
            en4 = 1'b0;
          end
          @(negedge clk);
        end
        en4 = 1'b0;
      end
      begin
        for (int k = 0; k < 10; k++) recv4(1);
      end
    join
    repeat (6) @(negedge clk);
    checks++;
    if (wi != 10 || count4 !== 3'd0 || q4.size() != 0) begin
      errors++;
      $display("FAIL wrap_stream: written=%0d count=%0d pending=%0d required 10,0,0", wi, count4, q4.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic seen;
    ack4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en4 = 1'b1; din4 = 16'h0031 + 16'(i); @(negedge clk);
    end
    en4 = 1'b0;
    n = 0;
    while (rqst4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rqst4 !== 1'b1 || count4 !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_pre: rqst=%b count=%0d required 1,3", rqst4, count4);
    end
    rst = 1'b1; en4 = 1'b1; din4 = 16'hDEAD;
    @(negedge clk);
    checks++;
    if (rqst4 !== 1'b0 || bus4 !== 16'h0 || count4 !== 3'd0 || full4 !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_flush: rqst=%b bus=%h count=%0d full=%b required 0,0000,0,0", rqst4, bus4, count4, full4);
    end
    rst = 1'b0; en4 = 1'b0;
    q4.delete();
    ack4 = 1'b1;
    repeat (4) @(negedge clk);
    ack4 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rqst4 !== 1'b0 || bus4 !== 16'h0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || count4 !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_no_txn: activity=%b count=%0d required 0,0", seen, count4);
    end
    do_single(16'h0055);
  endtask

  task automatic test_glitch();
    int n;
    int trans;
    logic prev;
    ack4 = 1'b0;
    en4 = 1'b1; din4 = 16'h00A1; q4.push_back(16'h00A1); @(negedge clk);
    din4 = 16'h00B2; q4.push_back(16'h00B2); @(negedge clk);
    en4 = 1'b0;
    n = 0;
    while (rqst4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (rqst4 !== 1'b1 || bus4 !== q4[0]) begin
      errors++;
      $display("FAIL glitch_pre: rqst=%b bus=%h required 1,%h", rqst4, bus4, q4[0]);
    end
    void'(q4.pop_front());
    ack4 = 1'b1;
    @(negedge clk);
    ack4 = 1'b0;
    trans = 0;
    prev = rqst4;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rqst4 !== prev) begin trans++; prev = rqst4; end
    end
    checks++;
    if (trans > 2) begin
      errors++;
      $display("FAIL glitch_transitions: rqst edges=%0d required at most 2", trans);
    end
    // A glitch the synchroniser missed leaves the first word still pending.
    if (bus4 === 16'h00A1) q4.push_front(16'h00A1);
    for (int k = 0; k < 3 && q4.size() > 0; k++) recv4(2);
    repeat (6) @(negedge clk);
    checks++;
    if (count4 !== 3'd0 || q4.size() != 0) begin
      errors++;
      $display("FAIL glitch_drain: count=%0d pending=%0d required 0,0", count4, q4.size());
    end
  endtask

  task automatic test_phase2();
    int toggles;
    int wi;
    logic prev;
    toggles = 0; wi = 1; prev = rqst2; ack2 = 1'b0;
    fork
      begin
        for (int c = 0; c < 200 && wi <= 8; c++) begin
          if (full2 === 1'b0) begin
            en2 = 1'b1; din2 = 16'(wi); q2.push_back(16'(wi)); wi++;
          end else begin
            en2 = 1'b0;
          end
          @(negedge clk);
        end
        en2 = 1'b0;
      end
      begin
        logic d1, d2;
        d1 = 1'b0; d2 = 1'b0;
        for (int c = 0; c < 250; c++) begin
          @(negedge clk);
          ack2 = d2; d2 = d1; d1 = rqst2;
        end
      end
      begin
        logic [15:0] want;
        for (int c = 0; c < 250 && toggles < 8; c++) begin
          @(negedge clk);
          if (rqst2 !== prev) begin
            prev = rqst2; toggles++;
            checks++;
            want = (q2.size() > 0) ? q2.pop_front() : 16'hXXXX;
            if (bus2 !== want) begin
              errors++;
              $display("FAIL p2_data: bus=%h required %h at toggle %0d", bus2, want, toggles);
            end
          end
        end
      end
    join
    checks++;
    if (toggles != 8 || count2 !== 3'd0 || q2.size() != 0) begin
      errors++;
      $display("FAIL p2_stream: toggles=%0d count=%0d pending=%0d required 8,0,0", toggles, count2, q2.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    en4 = 1'b0; din4 = '0; ack4 = 1'b0;
    en2 = 1'b0; din2 = '0; ack2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_full();
    test_simul_wrap();
    test_reset_mid();
    test_glitch();
    test_phase2();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
